// File: rtl/alu_sel_encoder.sv
// alu_sel_encoder: one-hot ALU request to 2-bit select, skid-buffered; ALU_SEL_ONEHOT_CHECK_EN drops malformed requests and raises ERR
module alu_sel_encoder (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_ADD,
  input  logic REQ_ANDI,
  input  logic REQ_SRAI,
  input  logic REQ_XOR,
  input  logic IN_VALID,
  output logic IN_READY,
  output logic SEL1,
  output logic SEL2,
  output logic OUT_VALID,
  input  logic OUT_READY,
  output logic ERR,
  input  logic ERR_CLR
);
  logic [3:0] req;
  logic [1:0] code, main_c, skid_c;
  logic main_v, skid_v, acc, tx, bad, store;
  assign req = {REQ_XOR, REQ_SRAI, REQ_ANDI, REQ_ADD};
  // priority XOR > SRAI > ANDI > ADD; identical to plain encoding for one-hot input
  assign code = {req[3] | req[2], req[3] | (~req[2] & req[1])};
  assign bad = (req == 4'd0) | ((req & (req - 4'd1)) != 4'd0);
  assign acc = IN_VALID & IN_READY;
  assign tx = main_v & OUT_READY;
  assign IN_READY = ~skid_v;
  assign OUT_VALID = main_v;
  assign {SEL1, SEL2} = main_c;
`ifdef ALU_SEL_ONEHOT_CHECK_EN
  assign store = acc & ~bad;
  always_ff @(posedge CLK or posedge RST)
    if (RST) ERR <= 1'b0;
    else ERR <= (acc & bad) ? 1'b1 : ERR_CLR ? 1'b0 : ERR;
`else
  logic unused_chk;
  assign store = acc;
  assign ERR = 1'b0;
  assign unused_chk = ERR_CLR | bad;
`endif
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      main_v <= 1'b0;
      main_c <= 2'd0;
      skid_v <= 1'b0;
      skid_c <= 2'd0;
    end else if (!main_v || tx) begin
      if (skid_v) begin
        main_v <= 1'b1;
        main_c <= skid_c;
        skid_v <= store;
        skid_c <= code;
      end else begin
        main_v <= store;
        main_c <= store ? code : main_c;
      end
    end else if (store) begin
      skid_v <= 1'b1;
      skid_c <= code;
    end
endmodule

// File: tb/tb_alu_sel_encoder.sv
// tb_alu_sel_encoder: queue-occupancy model of the encoder plus directed vectors with literal expectations
module tb_alu_sel_encoder;
  logic clk = 1'b0, rst, vld, ordy, eclr;
  logic [3:0] req;
  logic in_ready, sel1, sel2, out_valid, err;
  int checks = 0, failures = 0;
  int q[$], sent[$], got[$];
  bit merr = 1'b0;
  localparam [3:0] ADD = 4'b0001, ANDI = 4'b0010, SRAI = 4'b0100, XOR = 4'b1000;

  alu_sel_encoder dut (
    .CLK(clk), .RST(rst), .REQ_ADD(req[0]), .REQ_ANDI(req[1]), .REQ_SRAI(req[2]),
    .REQ_XOR(req[3]), .IN_VALID(vld), .IN_READY(in_ready), .SEL1(sel1), .SEL2(sel2),
    .OUT_VALID(out_valid), .OUT_READY(ordy), .ERR(err), .ERR_CLR(eclr)
  );

  always #5 clk = ~clk;

  function automatic int enc(logic [3:0] r);
    for (int i = 3; i >= 0; i--) if (r[i]) return i;
    return 0;
  endfunction

  function automatic bit malformed(logic [3:0] r);
    return $countones(r) != 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: the buffer is a FIFO of depth 2; ready means fewer than two held
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      merr = 1'b0;
    end else begin
      automatic bit acc = vld && q.size() < 2;
      automatic bit tx = q.size() > 0 && ordy;
      automatic bit keep = 1'b1;
`ifdef ALU_SEL_ONEHOT_CHECK_EN
      keep = !malformed(req);
      if (acc && malformed(req)) merr = 1'b1;
      else if (eclr) merr = 1'b0;
`endif
      if (tx) void'(q.pop_front());
      if (acc && keep) begin
        q.push_back(enc(req));
        sent.push_back(enc(req));
      end
    end

  always @(negedge clk) begin
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("err", err, merr);
    if (out_valid && q.size() > 0) chk("sel", {sel1, sel2}, q[0]);
    if (out_valid && ordy && !rst) got.push_back({sel1, sel2});
  end

  task automatic step(logic [3:0] r, logic v, logic o);
    req = r;
    vld = v;
    ordy = o;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(string name, int exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
    got.delete();
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; ordy = 1'b0; eclr = 1'b0; req = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel", {sel1, sel2}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err", err, 0);
    rst = 1'b0;
    // streaming, one per cycle
    step(ADD, 1, 1);
    chk("latency_valid", out_valid, 1);
    chk("latency_sel", {sel1, sel2}, 0);
    step(ANDI, 1, 1);
    step(SRAI, 1, 1);
    step(XOR, 1, 1);
    chk("stream_ready", in_ready, 1);
    repeat (2) step(0, 0, 1);
    chk_got("stream", '{0, 1, 2, 3});
    // backpressure: two accepted, third held off
    step(XOR, 1, 0);
    step(ADD, 1, 0);
    chk("bp_ready", in_ready, 0);
    chk("bp_sel", {sel1, sel2}, 3);
    step(SRAI, 1, 0);
    chk("bp_hold_sel", {sel1, sel2}, 3);
    step(SRAI, 1, 1);
    chk("bp_reready", in_ready, 1);
    step(SRAI, 1, 1);
    repeat (3) step(0, 0, 1);
    chk_got("bp_order", '{3, 0, 2});
    // alternating backpressure with continuous input
    sent.delete();
    for (int i = 0; i < 12; i++) step(4'b0001 << (i % 4), 1, i % 2);
    repeat (4) step(0, 0, 1);
    chk("alt_count", got.size(), sent.size());
    for (int i = 0; i < sent.size() && i < got.size(); i++) chk("alt_order", got[i], sent[i]);
    got.delete();
`ifdef ALU_SEL_ONEHOT_CHECK_EN
    step(ANDI | XOR, 1, 1);
    chk("mal_err", err, 1);
    chk("mal_no_out", out_valid, 0);
    eclr = 1'b1;
    step(ADD | SRAI, 1, 1);
    chk("mal_set_wins", err, 1);
    step(0, 0, 1);
    chk("mal_clr", err, 0);
    eclr = 1'b0;
    step(0, 0, 1);
    chk_got("mal_none", '{});
`else
    step(4'b0000, 1, 1);
    step(ANDI | SRAI, 1, 1);
    eclr = 1'b1;
    step(XOR | ADD, 1, 1);
    eclr = 1'b0;
    chk("nomac_err", err, 0);
    repeat (2) step(0, 0, 1);
    chk_got("nomac_codes", '{0, 2, 3});
`endif
    // reset with both entries full
    step(XOR, 1, 0);
    step(SRAI, 1, 0);
    chk("full_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sel", {sel1, sel2}, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_err", err, 0);
    step(0, 0, 1);
    rst = 1'b0;
    repeat (3) step(0, 0, 1);
    chk_got("post_rst", '{});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
